// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_scan_driver                                              |
// | Purpose  : N-digit time-multiplexed 7-segment driver. A packed BCD value |
// |            is captured into a shadow register on load_i and is only      |
// |            committed to the displayed register at the end of a frame, so |
// |            a frame never mixes old and new digits. Each digit slot       |
// |            begins with one dead cycle (all anodes off) to avoid ghosting.|
// | Ports    : clk, rst (sync, active-high)                                  |
// |            load_i, digits_i[4N]  - capture strobe / packed BCD value     |
// |            blank_lz_i            - live leading-zero blanking enable     |
// |            seg_o[7] {A..G}       - registered shared segment bus         |
// |            an_o[N]               - registered per-digit anode enables    |
// |            frame_o               - one-cycle pulse at each frame start   |
// | Options  : `define SEG7_SCAN_HEX_EN to display codes 10..15 as A..F     |
// |            (otherwise they display as 0 and count as zero).              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int N_DIGITS       = 3,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic                  blank_lz_i,
  output logic [6:0]            seg_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o
);

  localparam int   PW      = $clog2(SCAN_DIV);
  localparam int   IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_LOW  = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]          SEG_OFF = {7{SEG_LOW}};
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_LOW}};

  logic [4*N_DIGITS-1:0] pending;
  logic [4*N_DIGITS-1:0] active;
  logic [PW-1:0]         pre;
  logic [IW-1:0]         idx;

  logic                  pre_last;
  logic                  idx_last;
  logic [3:0]            cur_digit;
  logic [N_DIGITS-1:0]   an_hot;
  logic                  cur_upper_zero;
  logic                  zero_run;
  logic                  blank;
  logic [6:0]            seg_next;

  // Active-high ABCDEFG pattern for one code.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b1111110;
      4'd1:    pat = 7'b0110000;
      4'd2:    pat = 7'b1101101;
      4'd3:    pat = 7'b1111001;
      4'd4:    pat = 7'b0110011;
      4'd5:    pat = 7'b1011011;
      4'd6:    pat = 7'b1011111;
      4'd7:    pat = 7'b1110000;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1111011;
`ifdef SEG7_SCAN_HEX_EN
      4'd10:   pat = 7'b1110111;
      4'd11:   pat = 7'b0011111;
      4'd12:   pat = 7'b1001110;
      4'd13:   pat = 7'b0111101;
      4'd14:   pat = 7'b1001111;
      4'd15:   pat = 7'b1000111;
`endif
      default: pat = 7'b1111110;
    endcase
    return pat;
  endfunction

  // Whether a code counts as a non-zero digit for blanking purposes.
  function automatic logic nonzero(input logic [3:0] code);
`ifdef SEG7_SCAN_HEX_EN
    return (code != 4'd0);
`else
    return (code != 4'd0) && (code <= 4'd9);
`endif
  endfunction

  assign pre_last = (pre == PW'(SCAN_DIV - 1));
  assign idx_last = (idx == IW'(N_DIGITS - 1));

  // Select the scanned digit and work out whether it, together with every
  // more significant digit, is zero (scan from the MSD downwards).
  always_comb begin
    cur_digit      = 4'd0;
    an_hot         = '0;
    cur_upper_zero = 1'b0;
    zero_run       = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & ~nonzero(active[4*k +: 4]);
      if (idx == IW'(k)) begin
        cur_digit      = active[4*k +: 4];
        an_hot[k]      = 1'b1;
        cur_upper_zero = zero_run;
      end
    end
  end

  // Digit 0 is never blanked, so a value of zero still shows a single "0".
  assign blank    = blank_lz_i && cur_upper_zero && (idx != '0);
  assign seg_next = blank ? 7'b0000000 : decode(cur_digit);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      active  <= '0;
      pre     <= '0;
      idx     <= '0;
      seg_o   <= SEG_OFF;
      an_o    <= AN_OFF;
      frame_o <= 1'b0;
    end else begin
      if (load_i) begin
        pending <= digits_i;
      end
      // Commit takes the pending value as it stood before this edge, so a
      // load landing in the commit cycle waits for the next frame.
      if (pre_last && idx_last) begin
        active <= pending;
      end
      if (pre_last) begin
        pre <= '0;
        idx <= idx_last ? '0 : idx + IW'(1);
      end else begin
        pre <= pre + PW'(1);
      end

      // First cycle of every slot is dead time.
      if (pre == '0) begin
        seg_o <= SEG_OFF;
        an_o  <= AN_OFF;
      end else begin
        seg_o <= SEG_LOW ? ~seg_next : seg_next;
        an_o  <= AN_LOW ? ~an_hot : an_hot;
      end
      frame_o <= (pre == '0) && (idx == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seg7_scan_driver                                           |
// | Purpose  : Self-checking bench for seg7_scan_driver (N=3, SCAN_DIV=4).  |
// |            Two instances share the stimulus: one with active-low        |
// |            segments/anodes, one with active-high. Outputs are compared  |
// |            every cycle with a timeline model driven by the cycle count. |
// | Options  : honours SEG7_SCAN_HEX_EN in the reference decode.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seg7_scan_driver;

  localparam int N  = 3;
  localparam int SD = 4;
  localparam int FR = N * SD;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_i;
  logic [4*N-1:0] digits_i;
  logic          blank_lz_i;
  logic [6:0]    seg_lo, seg_hi;
  logic [N-1:0]  an_lo, an_hi;
  logic          frame_lo, frame_hi;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .rst(rst), .load_i(load_i), .digits_i(digits_i), .blank_lz_i(blank_lz_i),
    .seg_o(seg_lo), .an_o(an_lo), .frame_o(frame_lo)
  );

  seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst(rst), .load_i(load_i), .digits_i(digits_i), .blank_lz_i(blank_lz_i),
    .seg_o(seg_hi), .an_o(an_hi), .frame_o(frame_hi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: cycles since reset release, shadow and shown values.
  int             t;
  logic [4*N-1:0] m_pending;
  logic [4*N-1:0] m_active;
  logic           cur_bz;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int v);
    case (v)
      0: return 7'b1111110;  1: return 7'b0110000;
      2: return 7'b1101101;  3: return 7'b1111001;
      4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;
      8: return 7'b1111111;  9: return 7'b1111011;
`ifdef SEG7_SCAN_HEX_EN
      10: return 7'b1110111; 11: return 7'b0011111;
      12: return 7'b1001110; 13: return 7'b0111101;
      14: return 7'b1001111; 15: return 7'b1000111;
`endif
      default: return 7'b1111110;
    endcase
  endfunction

  function automatic bit counts_zero(input int v);
`ifdef SEG7_SCAN_HEX_EN
    return v == 0;
`else
    return (v == 0) || (v > 9);
`endif
  endfunction

  // One clock: apply inputs, predict the registered outputs from the model
  // state before the edge, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic ld, input logic [4*N-1:0] d, input logic bz);
    logic [6:0]   es;
    logic [N-1:0] ea;
    logic         ef;
    int           p, i;
    bit           all_zero;
    rst = r; load_i = ld; digits_i = d; blank_lz_i = bz;
    es = '0; ea = '0; ef = 1'b0;
    if (!r) begin
      p  = t % SD;
      i  = (t / SD) % N;
      ef = (t % FR) == 0;
      if (p != 0) begin
        ea[i] = 1'b1;
        all_zero = 1'b1;
        for (int k = i; k < N; k++)
          if (!counts_zero(int'((m_active >> (4*k)) & 4'hF))) all_zero = 1'b0;
        if (!(bz && i > 0 && all_zero))
          es = ref_seg(int'((m_active >> (4*i)) & 4'hF));
      end
    end
    if (r) begin
      t = 0; m_pending = '0; m_active = '0;
    end else begin
      if ((t % FR) == FR - 1) m_active = m_pending;
      if (ld) m_pending = d;
      t++;
    end
    @(posedge clk);
    #1;
    check("seg_lo",   {1'b0, seg_lo},   {1'b0, ~es});
    check("an_lo",    {5'b0, an_lo},    {5'b0, ~ea});
    check("frame_lo", {7'b0, frame_lo}, {7'b0, ef});
    check("seg_hi",   {1'b0, seg_hi},   {1'b0, es});
    check("an_hi",    {5'b0, an_hi},    {5'b0, ea});
    check("frame_hi", {7'b0, frame_hi}, {7'b0, ef});
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, '0, cur_bz);
  endtask

  task automatic load(input logic [4*N-1:0] d, input logic bz);
    cur_bz = bz;
    step(1'b0, 1'b1, d, bz);
    idle(2 * FR + 3);
  endtask

  task automatic align_to(input int phase);
    for (int j = 0; j < FR && (t % FR) != phase; j++) step(1'b0, 1'b0, '0, cur_bz);
  endtask

  initial begin
    t = 0; m_pending = '0; m_active = '0; cur_bz = 1'b0;
    rst = 1'b1; load_i = 1'b0; digits_i = '0; blank_lz_i = 1'b0;

    for (int j = 0; j < 3; j++) step(1'b1, 1'b0, '0, 1'b0);
    idle(FR + 2);

    load(12'h105, 1'b0);
    load(12'h007, 1'b1);
    load(12'h000, 1'b1);
    load(12'hA0C, 1'b1);
    load(12'hA0C, 1'b0);
    load(12'h888, 1'b0);

    // Load while digit 1 is being scanned.
    cur_bz = 1'b0;
    align_to(5);
    step(1'b0, 1'b1, 12'h321, cur_bz);
    idle(2 * FR);

    // Load in the commit cycle itself.
    align_to(FR - 1);
    step(1'b0, 1'b1, 12'h456, cur_bz);
    idle(2 * FR);

    // Reset between a load and its commit drops the pending value.
    align_to(3);
    step(1'b0, 1'b1, 12'h999, cur_bz);
    step(1'b1, 1'b0, '0, cur_bz);
    idle(2 * FR);

    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(0, 49) == 0) cur_bz = ~cur_bz;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
           (4*N)'($urandom), cur_bz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised N-digit time-multiplexed 7-segment display driver; successor to the per-digit combinational BCD decoders.
- Captures a packed BCD value on a load strobe, holds it in a shadow register, and commits it only at frame boundaries so the display never tears.
- Scans one digit at a time with anode dead-time, optional leading-zero blanking and a frame strobe.
- Sits between the counter/datapath and the board's shared segment bus plus per-digit anodes.

Parameters:
- N_DIGITS, 3: number of digits; legal range 1..8.
- SCAN_DIV, 1000: clocks per digit slot; minimum 2.
- SEG_ACTIVE_LOW, 1: 1 means seg_o is inverted (common anode); 0 means active-high.
- AN_ACTIVE_LOW, 1: 1 means an_o asserted level is 0; 0 means asserted level is 1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- load_i  in  1  capture strobe for digits_i.
- digits_i  in  4*N_DIGITS  packed BCD; nibble k is digit k; digit 0 is least significant.
- blank_lz_i  in  1  enables leading-zero blanking.
- seg_o  out  7  segments {A,B,C,D,E,F,G}, seg_o[6]=A; registered.
- an_o  out  N_DIGITS  digit enables; an_o[k] drives digit k; registered.
- frame_o  out  1  one-cycle pulse at each frame start.

Behaviour:
- Registers: pending[4N], active[4N], prescaler pre (0..SCAN_DIV-1), digit index idx (0..N_DIGITS-1).
- Reset (rst=1 at a clk edge):
  - pending=0, active=0, pre=0, idx=0.
  - seg_o = all segments off; an_o = all inactive; frame_o=0.
  - Reset mid-scan or mid-load drops any pending value.
- Prescaler and scan:
  - Each cycle pre increments.
  - At pre==SCAN_DIV-1: pre wraps to 0 and idx advances; idx wraps from N_DIGITS-1 to 0.
- Load:
  - load_i=1 writes digits_i into pending in that cycle; repeated loads overwrite, last one wins.
- Commit:
  - Occurs in the cycle where pre==SCAN_DIV-1 and idx==N_DIGITS-1: active<=pending.
  - A load_i in that same cycle goes to pending only; it appears one frame later.
- Output timing: outputs are registered and reflect (idx, pre, active) of the previous cycle, i.e. 1-cycle latency.
- Dead time: when pre==0, an_o is all inactive and seg_o is off. Otherwise only an_o[idx] is asserted and seg_o shows the decode of active digit idx.
- frame_o: asserted for exactly the one output cycle reflecting idx==0 and pre==0, i.e. the first cycle after each commit. The first pulse is in the first cycle after reset release.
- Decode, active-high ABCDEFG before polarity:

| Digit | ABCDEFG |
|---|---|
| 0 | 1111110 |
| 1 | 0110000 |
| 2 | 1101101 |
| 3 | 1111001 |
| 4 | 0110011 |
| 5 | 1011011 |
| 6 | 1011111 |
| 7 | 1110000 |
| 8 | 1111111 |
| 9 | 1111011 |

- Codes 10..15: decode as 0 and are treated as value 0 for blanking (feature off).
- Leading-zero blanking, when blank_lz_i=1:
  - Digit k is blanked (segments off, anode still asserted) if digits N-1..k of active are all zero and k>0.
  - Digit 0 is never blanked.
  - blank_lz_i is sampled live, not latched at commit.
- Polarity: applied last. Dead-time and "off" mean all-deasserted at the configured polarity.
- N_DIGITS=1: idx stays 0; every slot ends a frame.

Optional Feature:
- Macro: SEG7_SCAN_HEX_EN.
- When defined:
  - Codes 10..15 decode as A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - These codes count as non-zero for blanking.
- When undefined: codes 10..15 display 0 and count as zero, as stated above.

Test Plan (N_DIGITS=3, SCAN_DIV=4, both polarities low unless stated):
- Reset hold then release: first output cycle has an_o=111, seg_o=1111111, frame_o=1. Next cycle an_o=110 with seg_o=~1111110.
- load_i with digits_i=12'h105, blank_lz_i=0: after the next commit, slots show digit0 ~1011011 on an_o=110, digit1 ~1111110 on 101, digit2 ~0110000 on 011. Each slot is 3 active cycles after 1 dead cycle.
- digits_i=12'h007, blank_lz_i=1: digits 2 and 1 show seg_o=1111111 with anodes asserted; digit 0 shows ~1110000. With 12'h000, only digit 0 lights, showing ~1111110.
- Load mid-frame at idx=1: display unchanged until frame_o, then new value. A load coinciding with the commit cycle appears only after the following frame_o.
- digits_i=12'hA0C: feature off shows 0,0,0 (with blank_lz_i=1 only digit 0 lit). Feature on shows C, 0, A with nothing blanked.
- SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0: reset gives seg_o=0000000, an_o=000. Digit 8 gives seg_o=1111111 with its anode bit=1.
